// File: rtl/s2p_deser.sv
// s2p_deser: parametrised serial-to-parallel deserializer with valid/ack handshake and overrun flag
module s2p_deser #(
    parameter int WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             EN,
    input  logic             D,
    input  logic             SYNC,
    input  logic             ACK,
    input  logic             OVR_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             DR,
    output logic             OVR,
    output logic [CW-1:0]    BIT_CNT
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic             last;
    logic             done;

    // the word including the bit sampled this edge; bits older than a word fall off the end
    assign sr_nx = MSB_FIRST ? {sr[WIDTH-2:0], D} : {D, sr[WIDTH-1:1]};
    assign last  = BIT_CNT == CW'(WIDTH - 1);
    assign done  = EN && !SYNC && last;

    // shift register and bit counter; SYNC restarts the count, optionally with D as first bit
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            sr      <= '0;
            BIT_CNT <= '0;
        end else begin
            if (EN) sr <= sr_nx;
            if (SYNC) BIT_CNT <= EN ? CW'(1) : '0;
            else if (EN) BIT_CNT <= last ? '0 : BIT_CNT + CW'(1);
        end
    end

    // output word register with handshake; a word arriving while an old one is unacknowledged is dropped
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            Q   <= '0;
            DR  <= 1'b0;
            OVR <= 1'b0;
        end else begin
            if (done && (!DR || ACK)) Q <= sr_nx;
            DR  <= done || (DR && !ACK);
            OVR <= (done && DR && !ACK) || (OVR && !OVR_CLR);
        end
    end

endmodule

// File: doc/s2p_deser.md
Name: s2p_deser

Overview:
- Parametrised serial-to-parallel deserializer; next generation of the fixed 4-bit S2P converter.
- Accepts one serial bit per qualified clock, assembles WIDTH-bit words, and holds each word in an output register.
- Word delivery uses a valid/acknowledge handshake; unacknowledged words are overrun-protected.
- Adds frame resynchronisation and selectable bit order; sits between a serial receive front end and a word-oriented consumer.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 0, bit order. 0: first received bit lands in Q[0]. 1: first received bit lands in Q[WIDTH-1].

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- CLR_N  in  1  asynchronous active-low reset; clears all state immediately.
- EN  in  1  bit strobe; D is sampled only when EN=1.
- D  in  1  serial data bit.
- SYNC  in  1  frame restart. Discards the partial word; if EN=1 in the same cycle, D becomes bit 0 of the new word.
- ACK  in  1  consumer acknowledge; meaningful only while DR=1.
- OVR_CLR  in  1  synchronous clear of OVR.
- Q  out  WIDTH  last completed word.
- DR  out  1  data ready; high while Q holds an unacknowledged word.
- OVR  out  1  sticky overrun flag.
- BIT_CNT  out  clog2(WIDTH)  bits collected in the current partial word.

Behaviour:
- Reset (CLR_N=0, asynchronous): shift register=0, BIT_CNT=0, Q=0, DR=0, OVR=0. Reset mid-word discards the partial word. Normal operation resumes on the first rising edge after CLR_N goes high.
- Bit capture, EN=1:
  - MSB_FIRST=0: shift register shifts right with D entering the MSB.
  - MSB_FIRST=1: shift register shifts left with D entering the LSB.
  - BIT_CNT increments by 1.
- EN=0 and SYNC=0: shift register and BIT_CNT hold.
- Word complete: EN=1 with BIT_CNT=WIDTH-1.
  - The assembled word, including the current D, is the completed word.
  - BIT_CNT wraps to 0 on the same edge.
  - Shift register content beyond the completed word is don't-care.
- Latency: the completed word appears on Q, with DR=1, on the edge that samples the last bit. It is visible the cycle after that bit is presented.
- Handshake:
  - DR stays 1 and Q stays stable until the first edge where ACK=1. On that edge DR falls to 0, unless a new word completes on the same edge.
  - ACK while DR=0 is ignored.
- Simultaneous word complete and DR state:
  - DR=0: load Q, set DR=1.
  - DR=1 and ACK=1: load the new word into Q, DR stays 1, no overrun.
  - DR=1 and ACK=0: overrun. The new word is dropped, Q keeps the old word, DR stays 1, OVR is set to 1.
- OVR:
  - Sticky; cleared only by OVR_CLR=1 or by reset.
  - If OVR_CLR=1 on the same edge as a new overrun, set wins and OVR=1.
- SYNC=1:
  - BIT_CNT becomes 1 if EN=1 (D captured as the first bit), else 0.
  - Partial word discarded; no word completion is generated on that edge.
  - SYNC has priority over completion: SYNC=1 with BIT_CNT=WIDTH-1 and EN=1 starts a new word and leaves Q/DR unaffected except for ACK.
  - Q, DR and OVR are otherwise unaffected by SYNC.
- Continuous EN=1: one word every WIDTH cycles, with no dead cycle between words.
- BIT_CNT width: clog2(WIDTH), minimum 1 bit. Counter compares against WIDTH-1, so non-power-of-2 widths wrap correctly.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=0, EN=1, send bits 1,0,1,1,0,0,1,0 (first to last) -> Q=8'h4D with DR=1 the cycle after the 8th bit; BIT_CNT=0.
- Same stream with MSB_FIRST=1 -> Q=8'hB2.
- Two back-to-back words 8'hA5 then 8'h3C, ACK held low -> Q stays 8'hA5, DR=1, OVR=1. Then OVR_CLR and ACK pulse -> OVR=0, DR=0.
- Same two words with ACK=1 on the 8th bit of the second word -> Q=8'h3C, DR=1, OVR=0.
- Send 5 bits, then SYNC=1 with EN=1 and D=1, then 7 more bits -> partial word discarded; completed word has the SYNC bit as its first bit.
- Assert CLR_N low asynchronously between clock edges mid-word with DR=1 and OVR=1 -> Q, DR, OVR and BIT_CNT go to 0 immediately. A full word after release decodes correctly. Repeat with WIDTH=5 to check counter wrap.
